// File: rtl/seq_det_pkg.sv
// Shared definitions for the run-time-loadable serial sequence detector.
// Provides the state-width helper, overlap mode constants and a PAT_LEN range check.
`define SEQ_DET_CHECK_PAT_LEN(n) \
    if ((n) < 2 || (n) > 16) begin : g_bad_pat_len \
        $error("seq_detector: PAT_LEN must be within 2..16"); \
    end

package seq_det_pkg;

    localparam int unsigned SEQ_OVL  = 1;
    localparam int unsigned SEQ_NOVL = 0;

    function automatic int unsigned st_w(input int unsigned pat_len);
        return $clog2(pat_len + 1);
    endfunction

endpackage

// File: rtl/seq_det_next.sv
// Failure-function transition: given the pattern, a base prefix length and a new bit,
// returns the longest pattern prefix that is a suffix of {pattern[0 +: kb], bit}.
module seq_det_next
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_LEN = 3,
    parameter int unsigned ST_W    = 2
) (
    input  logic [PAT_LEN-1:0] i_pat,
    input  logic [ST_W-1:0]    i_kb,
    input  logic               i_bit,
    output logic [ST_W-1:0]    o_next
);

    localparam int          PL = int'(PAT_LEN);
    localparam int unsigned IW = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;

    logic w_ok;
    logic w_found;
    int   w_kb_i;

    // Candidate lengths are tried longest first; bit p of the pattern (first received = 0) is i_pat[PL-1-p].
    always_comb begin
        o_next  = '0;
        w_found = 1'b0;
        w_ok    = 1'b0;
        w_kb_i  = int'(i_kb);
        for (int j = PL; j >= 1; j--) begin
            w_ok = (j <= w_kb_i + 1) && (i_pat[IW'(PL - j)] == i_bit);
            for (int i = 0; i < PL - 1; i++) begin
                if (i < j - 1) begin
                    w_ok = w_ok && (i_pat[IW'(PL - 1 - i)] ==
                                    i_pat[IW'(PL - 1 - (w_kb_i - j + 1 + i))]);
                end
            end
            if (w_ok && !w_found) begin
                o_next  = ST_W'(j);
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_detector.sv
// Moore serial pattern detector with loadable pattern, overlap control and a
// saturating match counter.
module seq_detector
    import seq_det_pkg::*;
#(
    parameter int unsigned        PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0] PATTERN = 3'b101,
    parameter int unsigned        OVERLAP = 1,
    parameter int unsigned        CNT_W   = 8,
    localparam int unsigned       ST_W    = st_w(PAT_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               input_bit,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [PAT_LEN-1:0] cfg_pattern,
    input  logic               clr_cnt,
    output logic [ST_W-1:0]    state,
    output logic               match,
    output logic [CNT_W-1:0]   match_count
);

    `SEQ_DET_CHECK_PAT_LEN(PAT_LEN)

    if (OVERLAP != SEQ_OVL && OVERLAP != SEQ_NOVL) begin : g_bad_overlap
        $error("seq_detector: OVERLAP must be 0 or 1");
    end

    localparam logic [ST_W-1:0]  FULL    = ST_W'(PAT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PAT_LEN-1:0] r_pat;
    logic [ST_W-1:0]    r_state;
    logic               r_match;
    logic [CNT_W-1:0]   r_cnt;

    logic [PAT_LEN-1:0] w_pat_nxt;
    logic [ST_W-1:0]    w_state_nxt;
    logic               w_match_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [ST_W-1:0]    w_kb;
    logic [ST_W-1:0]    w_next;
    logic               w_hit;

    // From the full state, overlap continues from the whole pattern; otherwise restart.
    assign w_kb = (r_state != FULL) ? r_state :
                  ((OVERLAP == SEQ_OVL) ? FULL : '0);

    seq_det_next #(
        .PAT_LEN (PAT_LEN),
        .ST_W    (ST_W)
    ) u_next (
        .i_pat  (r_pat),
        .i_kb   (w_kb),
        .i_bit  (input_bit),
        .o_next (w_next)
    );

    always_comb begin
        w_pat_nxt   = r_pat;
        w_state_nxt = r_state;
        w_match_nxt = r_match;
        w_cnt_nxt   = r_cnt;
        w_hit       = 1'b0;
        if (cfg_load) begin
            w_pat_nxt   = cfg_pattern;
            w_state_nxt = '0;
            w_match_nxt = 1'b0;
        end else if (in_valid) begin
            w_state_nxt = w_next;
            w_match_nxt = (w_next == FULL);
            w_hit       = (w_next == FULL);
        end
        if (clr_cnt) begin
            w_cnt_nxt = '0;
        end else if (w_hit && r_cnt != CNT_MAX) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat   <= PATTERN;
            r_state <= '0;
            r_match <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_pat   <= w_pat_nxt;
            r_state <= w_state_nxt;
            r_match <= w_match_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign state       = r_state;
    assign match       = r_match;
    assign match_count = r_cnt;

endmodule

// File: tb/tb_seq_detector.sv
// Scoreboard bench for seq_detector: three parameterisations driven in turn,
// expected post-edge outputs queued by the driver and checked by a monitor.
module tb_seq_detector;

    typedef struct {
        int    id;
        int    st;
        int    m;
        int    cnt;
        string nm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_in = 1'b0;
    logic       vld = 1'b0;
    logic       ld = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] pat = 4'b0000;
    int         sel = 0;

    logic [1:0] a_state, b_state;
    logic [2:0] c_state;
    logic       a_match, b_match, c_match;
    logic [7:0] a_cnt, b_cnt;
    logic [1:0] c_cnt;

    int   checks = 0;
    int   failures = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    seq_detector u_a (
        .clk(clk), .rst(rst), .input_bit(bit_in), .in_valid(vld && sel == 0),
        .cfg_load(ld && sel == 0), .cfg_pattern(pat[2:0]), .clr_cnt(clr && sel == 0),
        .state(a_state), .match(a_match), .match_count(a_cnt)
    );

    seq_detector #(.OVERLAP(0)) u_b (
        .clk(clk), .rst(rst), .input_bit(bit_in), .in_valid(vld && sel == 1),
        .cfg_load(ld && sel == 1), .cfg_pattern(pat[2:0]), .clr_cnt(clr && sel == 1),
        .state(b_state), .match(b_match), .match_count(b_cnt)
    );

    seq_detector #(.PAT_LEN(4), .PATTERN(4'b1001), .CNT_W(2)) u_c (
        .clk(clk), .rst(rst), .input_bit(bit_in), .in_valid(vld && sel == 2),
        .cfg_load(ld && sel == 2), .cfg_pattern(pat), .clr_cnt(clr && sel == 2),
        .state(c_state), .match(c_match), .match_count(c_cnt)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_dut(input int id, input string nm, input int es, input int em, input int ec);
        int st, m, cnt;
        case (id)
            0:       begin st = int'(a_state); m = int'(a_match); cnt = int'(a_cnt); end
            1:       begin st = int'(b_state); m = int'(b_match); cnt = int'(b_cnt); end
            default: begin st = int'(c_state); m = int'(c_match); cnt = int'(c_cnt); end
        endcase
        chk({nm, ".state"}, st, es);
        chk({nm, ".match"}, m, em);
        chk({nm, ".count"}, cnt, ec);
    endtask

    // Drive one edge worth of stimulus for DUT id and queue its expected post-edge outputs.
    task automatic step(input int id, input string nm, input bit b, input bit v, input bit l,
                        input logic [3:0] p, input bit c, input int es, input int em, input int ec);
        exp_t e;
        @(negedge clk);
        sel = id; bit_in = b; vld = v; ld = l; pat = p; clr = c;
        e.id = id; e.st = es; e.m = em; e.cnt = ec; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        vld = 1'b0; ld = 1'b0; clr = 1'b0; bit_in = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk_dut(e.id, e.nm, e.st, e.m, e.cnt);
            end
        end
    end

    initial begin : driver
        int ones[6];
        int acnt[6];
        repeat (2) @(posedge clk);
        #1;
        chk_dut(0, "rst_a", 0, 0, 0);
        chk_dut(1, "rst_b", 0, 0, 0);
        chk_dut(2, "rst_c", 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Overlapping 101 on stream 1,0,1,0,1.
        step(0, "a_s1", 1, 1, 0, 4'h0, 0, 1, 0, 0);
        step(0, "a_s2", 0, 1, 0, 4'h0, 0, 2, 0, 0);
        step(0, "a_s3", 1, 1, 0, 4'h0, 0, 3, 1, 1);
        step(0, "a_s4", 0, 1, 0, 4'h0, 0, 2, 0, 1);
        step(0, "a_s5", 1, 1, 0, 4'h0, 0, 3, 1, 2);
        for (int i = 0; i < 5; i++) step(0, "a_hold", 1, 0, 0, 4'h0, 0, 3, 1, 2);
        step(0, "a_load", 1, 1, 1, 4'b0011, 0, 0, 0, 2);
        step(0, "a_n1", 0, 1, 0, 4'h0, 0, 1, 0, 2);
        step(0, "a_n2", 1, 1, 0, 4'h0, 0, 2, 0, 2);
        step(0, "a_n3", 1, 1, 0, 4'h0, 0, 3, 1, 3);

        // Non-overlapping 101 on the same stream.
        step(1, "b_s1", 1, 1, 0, 4'h0, 0, 1, 0, 0);
        step(1, "b_s2", 0, 1, 0, 4'h0, 0, 2, 0, 0);
        step(1, "b_s3", 1, 1, 0, 4'h0, 0, 3, 1, 1);
        step(1, "b_s4", 0, 1, 0, 4'h0, 0, 0, 0, 1);
        step(1, "b_s5", 1, 1, 0, 4'h0, 0, 1, 0, 1);

        // PAT_LEN=4, CNT_W=2: all-ones pattern, saturation and clear priority.
        step(2, "c_load", 0, 0, 1, 4'b1111, 0, 0, 0, 0);
        ones = '{1, 2, 3, 4, 4, 4};
        acnt = '{0, 0, 0, 1, 2, 3};
        for (int i = 0; i < 6; i++)
            step(2, "c_ones", 1, 1, 0, 4'h0, 0, ones[i], (ones[i] == 4) ? 1 : 0, acnt[i]);
        step(2, "c_zero", 0, 1, 0, 4'h0, 0, 0, 0, 3);
        step(2, "c_r1", 1, 1, 0, 4'h0, 0, 1, 0, 3);
        step(2, "c_r2", 1, 1, 0, 4'h0, 0, 2, 0, 3);
        step(2, "c_r3", 1, 1, 0, 4'h0, 0, 3, 0, 3);
        step(2, "c_sat4", 1, 1, 0, 4'h0, 0, 4, 1, 3);
        step(2, "c_sat5", 1, 1, 0, 4'h0, 0, 4, 1, 3);
        step(2, "c_clr6", 1, 1, 0, 4'h0, 1, 4, 1, 0);
        step(2, "c_inc7", 1, 1, 0, 4'h0, 0, 4, 1, 1);
        step(2, "c_p0", 0, 1, 0, 4'h0, 0, 0, 0, 1);
        step(2, "c_p1", 1, 1, 0, 4'h0, 0, 1, 0, 1);
        step(2, "c_p2", 1, 1, 0, 4'h0, 0, 2, 0, 1);
        idle();

        // Asynchronous reset pulse between edges while at state 2.
        #2 rst = 1'b1;
        #1;
        chk_dut(2, "c_async", 0, 0, 0);
        #1 rst = 1'b0;

        // Pattern register must be back at 1001.
        step(2, "c_d1", 1, 1, 0, 4'h0, 0, 1, 0, 0);
        step(2, "c_d2", 0, 1, 0, 4'h0, 0, 2, 0, 0);
        step(2, "c_d3", 0, 1, 0, 4'h0, 0, 3, 0, 0);
        step(2, "c_d4", 1, 1, 0, 4'h0, 0, 4, 1, 1);
        idle();

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        chk("drain", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_detector.md
# seq_detector

Parametrised Moore sequence detector: tracks the longest received prefix of a PAT_LEN-bit pattern on a serial bit stream, raises `match` while a full pattern has just been received, and counts matches. The pattern is loadable at run time, and the block supports overlapping and non-overlapping detection. It sits between a serial front end (bit deserialiser or debounced input) and status/LED logic, and replaces the fixed 3-bit detectors.

## Interface
- `PAT_LEN`, default 3: pattern length in bits; legal range 2..16.
- `PATTERN`, default 3'b101: reset value of the pattern register. MSB is the first bit received.
- `OVERLAP`, default 1: 1 = overlapping detection, 0 = non-overlapping.
- `CNT_W`, default 8: match counter width.
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `input_bit`  input  1  serial data bit.
- `in_valid`  input  1  `input_bit` is consumed on this edge; when low, all state holds.
- `cfg_load`  input  1  load `cfg_pattern` into the pattern register.
- `cfg_pattern`  input  PAT_LEN  new pattern, MSB first.
- `clr_cnt`  input  1  synchronous clear of `match_count`.
- `state`  output  ST_W  current matched-prefix length, 0..PAT_LEN. ST_W = $clog2(PAT_LEN+1).
- `match`  output  1  high iff `state` == PAT_LEN.
- `match_count`  output  CNT_W  saturating count of completed matches.

## Operation
- The state is the prefix length k: the last k consumed bits equal `pat[PAT_LEN-1 -: k]`. Reset state is 0.
- Next state on a valid bit b is taken from a base length kb:
  - kb = k when k < PAT_LEN.
  - kb = PAT_LEN when k = PAT_LEN and OVERLAP = 1.
  - kb = 0 when k = PAT_LEN and OVERLAP = 0.
- Next state = the largest j, 0 ≤ j ≤ min(kb+1, PAT_LEN), such that the length-j pattern prefix equals the last j bits of {first kb pattern bits, b}. This is the failure-function (KMP) transition; no history shift register is used.
- Moore output: `match` is decoded from the `state` register only, never from `input_bit`. It stays high while `in_valid` is low in the full state.
- `match_count` increments by 1 on every edge where `in_valid` = 1 and the next state = PAT_LEN. This includes full→full transitions in overlap mode, for example an all-ones pattern. The count saturates at 2^CNT_W−1.
- `cfg_load` = 1: the pattern register takes `cfg_pattern` and the state goes to 0. Any `in_valid` bit on the same edge is dropped and the count is unchanged.
- `clr_cnt` = 1: the count goes to 0, and this wins over a simultaneous increment. State tracking is unaffected.
- Reset values: state 0, `match` 0, `match_count` 0, pattern register = PATTERN.
- Asserting `rst` mid-sequence discards the partial prefix immediately (asynchronous). The first post-reset bit is treated as the start of a new stream.

## Timing
- Bit sampled on edge N → `state`, `match` and `match_count` reflect it after edge N. Latency is one cycle from the last pattern bit to `match` high.
- No combinational path from any input to any output.
- `cfg_load` takes effect on its edge. Detection with the new pattern starts with the bit on the following valid edge.
- Throughput is one bit per clock. `in_valid` may toggle every cycle with no required gaps.

## Structure
- Shared package/header `seq_det_pkg`:
  - ST_W computation function.
  - OVERLAP mode constants (`SEQ_OVL`, `SEQ_NOVL`).
  - Legal-range check macro for PAT_LEN.
- Sub-module `seq_det_next`: purely combinational (pattern, kb, b) → next prefix length, implemented as a priority search over j from high to low.
- The top level holds the pattern register, state register, counter, and control priority: rst > cfg_load > in_valid; clr_cnt is independent.

## Test plan
- Default params, stream 1,0,1,0,1 → state 1,2,3,2,3; `match` high after bits 3 and 5; count = 2.
- OVERLAP=0, same stream → state 1,2,3,0,1; one match; count = 1.
- PAT_LEN=4, `cfg_load` 4'b1111, stream of six 1s → `match` high from bit 4 onward; count = 3. Then one 0 → state 0, `match` low.
- Hold `in_valid` low for 5 cycles in the full state → `match` stays high, count unchanged. `cfg_load` with `in_valid` = 1 on the same edge → state 0, bit dropped.
- CNT_W=2, five matches → count saturates at 3. `clr_cnt` on the same edge as a sixth match → count 0.
- `rst` pulsed asynchronously between edges at state 2 → state/`match`/count 0 before the next edge; pattern returns to PATTERN.
